// File: rtl/line_clear_engine.sv
// line_clear_engine: compacts the 20x10 board after a piece locks. It scans bottom-up,
// drops full rows, zero-fills the vacated top rows, and updates the running and best score.
module line_clear_engine #(
  parameter int ROWS    = 20,
  parameter int COLS    = 10,
  parameter int CELL_W  = 5,
  parameter int SCORE_W = 20
) (
  input  logic                   CLOCK_50,
  input  logic                   RESET_N,
  input  logic                   start,
  input  logic                   clear_score,
  output logic [4:0]             row_raddr,
  input  logic [COLS*CELL_W-1:0] row_rdata,
  output logic [4:0]             row_waddr,
  output logic                   row_we,
  output logic [COLS*CELL_W-1:0] row_wdata,
  output logic                   busy,
  output logic                   done,
  output logic [2:0]             lines,
  output logic [SCORE_W-1:0]     score,
  output logic [SCORE_W-1:0]     best_score
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SCAN  = 3'd1;
  localparam logic [2:0] S_FILL  = 3'd2;
  localparam logic [2:0] S_SCORE = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [4:0] LAST_ROW = 5'(ROWS - 1);

  logic [2:0]         r_state;
  logic [4:0]         r_rd;
  logic [4:0]         r_wr;
  logic [4:0]         r_cnt;
  logic               w_full;
  logic [4:0]         w_cnt_nxt;
  logic [SCORE_W-1:0] w_sum;

  // Tetris line reward; anything beyond four lines is paid as a Tetris.
  function automatic logic [SCORE_W-1:0] line_points(input logic [4:0] n);
    case (n)
      5'd0:    line_points = '0;
      5'd1:    line_points = SCORE_W'(40);
      5'd2:    line_points = SCORE_W'(100);
      5'd3:    line_points = SCORE_W'(300);
      default: line_points = SCORE_W'(1200);
    endcase
  endfunction

  // Unsigned add that clamps at the all-ones score instead of wrapping.
  function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] a,
                                                 input logic [SCORE_W-1:0] b);
    logic [SCORE_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    sat_add = s[SCORE_W] ? {SCORE_W{1'b1}} : s[SCORE_W-1:0];
  endfunction

  // A row is full only when every cell holds a locked colour (1..9).
  always_comb begin
    w_full = 1'b1;
    for (int c = 0; c < COLS; c++) begin
      if ((row_rdata[c*CELL_W +: CELL_W] == '0) ||
          (row_rdata[c*CELL_W +: CELL_W] > CELL_W'(9)))
        w_full = 1'b0;
    end
  end

  assign w_cnt_nxt = r_cnt + {4'd0, w_full};
  assign w_sum     = sat_add(score, line_points(r_cnt));

  // Board port drive: copy surviving rows down during the scan, zeros during the fill.
  always_comb begin
    row_raddr = LAST_ROW;
    row_waddr = '0;
    row_we    = 1'b0;
    row_wdata = '0;
    busy      = (r_state != S_IDLE);
    done      = (r_state == S_DONE);
    case (r_state)
      S_SCAN: begin
        row_raddr = r_rd;
        if (!w_full && (r_rd != r_wr)) begin
          row_we    = 1'b1;
          row_waddr = r_wr;
          row_wdata = row_rdata;
        end
      end
      S_FILL: begin
        row_we    = 1'b1;
        row_waddr = r_wr;
      end
      default: ;
    endcase
  end

  // Pass sequencer: read pointer walks every row, write pointer trails it past full rows.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state <= S_IDLE;
      r_rd    <= LAST_ROW;
      r_wr    <= LAST_ROW;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_rd    <= LAST_ROW;
            r_wr    <= LAST_ROW;
            r_cnt   <= '0;
            r_state <= S_SCAN;
          end
        end
        S_SCAN: begin
          if (w_full) r_cnt <= w_cnt_nxt;
          else        r_wr  <= r_wr - 5'd1;
          r_rd <= r_rd - 5'd1;
          // Stop on the row-0 cycle itself; the 5-bit pointer would wrap one step later.
          if (r_rd == 5'd0)
            r_state <= (w_cnt_nxt != 5'd0) ? S_FILL : S_SCORE;
        end
        S_FILL: begin
          r_wr <= r_wr - 5'd1;
          if (r_wr == 5'd0) r_state <= S_SCORE;
        end
        S_SCORE: r_state <= S_DONE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Score bookkeeping; a coincident clear_score overrides the new score but best still sees the sum.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      lines      <= '0;
      score      <= '0;
      best_score <= '0;
    end else begin
      if (r_state == S_SCORE) begin
        lines <= (r_cnt > 5'd7) ? 3'd7 : r_cnt[2:0];
        score <= w_sum;
        if (w_sum > best_score) best_score <= w_sum;
      end
      if (clear_score) score <= '0;
    end
  end

endmodule
